// File: rtl/sram_responder_if.sv
// Valid/ready bus between a core-side requester and the SRAM responder.
// Read address/data and write address/data/response channels, AXI4-Lite style.
interface sram_responder_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/sram_responder.sv
// Multi-cycle SRAM responder: independent read and write FSMs, each with one
// outstanding transaction, fixed extra latency and full response backpressure.
module sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  sram_responder_if.slave io_bus
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LP_SPAN   = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LP_RD_LAT = 4'(RD_LAT);
  localparam logic [3:0]  LP_WR_LAT = 4'(WR_LAT);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_DEC  = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_e;

  // Address below the base wraps to a huge 33-bit offset, so one compare covers both ends.
  function automatic logic f_in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, ADDR_BASE};
    return (off < LP_SPAN);
  endfunction

  // Word index of a byte address; the two byte-lane bits are dropped.
  function automatic logic [IDX_W-1:0] f_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return off[IDX_W+1:2];
  endfunction

  // Byte-enable merge of new write data over the stored word.
  function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] r_mem [DEPTH_WORDS];

  rd_state_e   r_rd_state, w_rd_next;
  logic [3:0]  r_rd_cnt;
  logic [31:0] r_rd_addr;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_rd_enter_resp;
  logic [31:0] w_rd_sample_addr;

  wr_state_e   w_wr_next, r_wr_state;
  logic        r_aw_got, r_w_got;
  logic [31:0] r_wr_addr, r_wr_data;
  logic [3:0]  r_wr_strb;
  logic [3:0]  r_wr_cnt;
  logic [1:0]  r_bresp;
  logic        w_aw_fire, w_w_fire, w_wr_both, w_wr_enter_resp;
  logic [31:0] w_cm_addr, w_cm_data;
  logic [3:0]  w_cm_strb;

  // Read FSM next state.
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE: begin
        if (io_bus.arvalid) begin
          w_rd_next = (LP_RD_LAT == 4'd0) ? R_RESP : R_WAIT;
        end else begin
          w_rd_next = R_IDLE;
        end
      end
      R_WAIT: begin
        if (r_rd_cnt == 4'd0) begin
          w_rd_next = R_RESP;
        end else begin
          w_rd_next = R_WAIT;
        end
      end
      R_RESP: begin
        if (io_bus.rready) begin
          w_rd_next = R_IDLE;
        end else begin
          w_rd_next = R_RESP;
        end
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // Read sample point: with zero latency the address comes straight off the bus.
  always_comb begin
    w_rd_enter_resp = (r_rd_state != R_RESP) && (w_rd_next == R_RESP);
    if (r_rd_state == R_IDLE) begin
      w_rd_sample_addr = io_bus.araddr;
    end else begin
      w_rd_sample_addr = r_rd_addr;
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_state <= R_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  // Read address latch and latency countdown.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_cnt  <= 4'd0;
      r_rd_addr <= 32'd0;
    end else if ((r_rd_state == R_IDLE) && io_bus.arvalid) begin
      r_rd_cnt  <= LP_RD_LAT;
      r_rd_addr <= io_bus.araddr;
    end else if ((r_rd_state == R_WAIT) && (r_rd_cnt != 4'd0)) begin
      r_rd_cnt  <= r_rd_cnt - 4'd1;
    end
  end

  // Read response register, loaded once on entry to R_RESP and then held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= 32'd0;
      r_rresp <= RESP_OKAY;
    end else if (w_rd_enter_resp) begin
      if (f_in_range(w_rd_sample_addr)) begin
        r_rdata <= r_mem[f_index(w_rd_sample_addr)];
        r_rresp <= RESP_OKAY;
      end else begin
        r_rdata <= 32'd0;
        r_rresp <= RESP_DEC;
      end
    end
  end

  // Write channel captures and commit source (registered copy once captured).
  always_comb begin
    w_aw_fire = (r_wr_state == W_IDLE) && !r_aw_got && io_bus.awvalid;
    w_w_fire  = (r_wr_state == W_IDLE) && !r_w_got  && io_bus.wvalid;
    w_wr_both = (r_wr_state == W_IDLE) && (r_aw_got || w_aw_fire) && (r_w_got || w_w_fire);
    if (r_aw_got) w_cm_addr = r_wr_addr;
    else          w_cm_addr = io_bus.awaddr;
    if (r_w_got) begin
      w_cm_data = r_wr_data;
      w_cm_strb = r_wr_strb;
    end else begin
      w_cm_data = io_bus.wdata;
      w_cm_strb = io_bus.wstrb;
    end
  end

  // Write FSM next state.
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE: begin
        if (w_wr_both) begin
          w_wr_next = (LP_WR_LAT == 4'd0) ? W_RESP : W_WAIT;
        end else begin
          w_wr_next = W_IDLE;
        end
      end
      W_WAIT: begin
        if (r_wr_cnt == 4'd0) w_wr_next = W_RESP;
        else                  w_wr_next = W_WAIT;
      end
      W_RESP: begin
        if (io_bus.bready) w_wr_next = W_IDLE;
        else               w_wr_next = W_RESP;
      end
      default: w_wr_next = W_IDLE;
    endcase
    w_wr_enter_resp = (r_wr_state != W_RESP) && (w_wr_next == W_RESP);
  end

  // Write FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_wr_state <= W_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  // AW/W capture flags and holding registers; cleared by the B handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_wr_addr <= 32'd0;
      r_wr_data <= 32'd0;
      r_wr_strb <= 4'd0;
    end else if ((r_wr_state == W_RESP) && io_bus.bready) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
    end else begin
      if (w_aw_fire) begin
        r_aw_got  <= 1'b1;
        r_wr_addr <= io_bus.awaddr;
      end
      if (w_w_fire) begin
        r_w_got   <= 1'b1;
        r_wr_data <= io_bus.wdata;
        r_wr_strb <= io_bus.wstrb;
      end
    end
  end

  // Write latency countdown.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                            r_wr_cnt <= 4'd0;
    else if (w_wr_both)                                   r_wr_cnt <= LP_WR_LAT;
    else if ((r_wr_state == W_WAIT) && (r_wr_cnt != 4'd0)) r_wr_cnt <= r_wr_cnt - 4'd1;
  end

  // Write response register, loaded on entry to W_RESP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bresp <= RESP_OKAY;
    end else if (w_wr_enter_resp) begin
      r_bresp <= f_in_range(w_cm_addr) ? RESP_OKAY : RESP_DEC;
    end
  end

  // Array commit; uninitialised storage, so no reset of contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_enter_resp && f_in_range(w_cm_addr)) begin
      r_mem[f_index(w_cm_addr)] <= f_merge(r_mem[f_index(w_cm_addr)], w_cm_data, w_cm_strb);
    end
  end

  // Handshake outputs decoded from FSM state only.
  always_comb begin
    io_bus.arready = (r_rd_state == R_IDLE);
    io_bus.rvalid  = (r_rd_state == R_RESP);
    io_bus.awready = (r_wr_state == W_IDLE) && !r_aw_got;
    io_bus.wready  = (r_wr_state == W_IDLE) && !r_w_got;
    io_bus.bvalid  = (r_wr_state == W_RESP);
  end

  assign io_bus.rdata = r_rdata;
  assign io_bus.rresp = r_rresp;
  assign io_bus.bresp = r_bresp;

endmodule
